nwc_input_loader: RTL and testbench

//  Upstream stage of the NWC processor top. Accepts two polynomials as a valid/ready coefficient

---
 rtl/nwc_input_loader.sv | 157 +++++++++++++++
 tb/tb_nwc_input_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nwc_input_loader.sv
// Loads polynomials A and B from a valid/ready stream into the two NWC input RAMs, then starts the top.
// Optional macro NWC_LOADER_RANGE_CHECK_EN: flag and clear coefficient bits [63:60] on write.
module nwc_input_loader #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0,
  output logic [7:0]        wen0,
  output logic [ADDR_W-1:0] addr1,
  output logic [DATA_W-1:0] din1,
  output logic [7:0]        wen1,
  output logic              nwc_start,
  input  logic              nwc_done,
  output logic              busy,
  output logic              run_done,
  output logic              err_frame,
  output logic              err_range
);

  localparam int unsigned COEF_W = 60;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    LOAD_A   = 3'd0,
    LOAD_B   = 3'd1,
    FLUSH    = 3'd2,
    START    = 3'd3,
    WAIT_CLR = 3'd4,
    WAIT_DN  = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] count, count_nx;
  logic              beat;
  logic              at_last;

  logic              ready_nx, start_nx, busy_nx, run_done_nx;
  logic              frame_nx, range_nx;
  logic [ADDR_W-1:0] addr0_nx, addr1_nx;
  logic [DATA_W-1:0] din0_nx, din1_nx, data_w;
  logic [7:0]        wen0_nx, wen1_nx;
  logic              over_c;

  assign beat    = s_valid & s_ready;
  assign at_last = (count == LAST_IDX);

  // State and coefficient counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD_A;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // Next state: polynomial length, not s_last, decides the A/B boundary
  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      LOAD_A: begin
        if (beat) begin
          count_nx = count + ADDR_W'(1);
          if (at_last) state_nx = LOAD_B;
        end
      end
      LOAD_B: begin
        if (beat) begin
          count_nx = count + ADDR_W'(1);
          if (at_last) state_nx = FLUSH;
        end
      end
      FLUSH:    state_nx = START;
      START:    state_nx = WAIT_CLR;
      WAIT_CLR: if (!nwc_done) state_nx = WAIT_DN;
      WAIT_DN:  if (nwc_done) state_nx = LOAD_A;
      default:  state_nx = LOAD_A;
    endcase
  end

  // Write data conditioning
  always_comb begin
`ifdef NWC_LOADER_RANGE_CHECK_EN
    over_c = |s_data[DATA_W-1:COEF_W];
    data_w = {(DATA_W-COEF_W)'(0), s_data[COEF_W-1:0]};
`else
    over_c = 1'b0;
    data_w = s_data;
`endif
  end

  // Output next values, decoded from the upcoming state so every output is a flop
  always_comb begin
    ready_nx    = (state_nx == LOAD_A) || (state_nx == LOAD_B);
    start_nx    = (state_nx == START);
    busy_nx     = (state_nx == START) || (state_nx == WAIT_CLR) || (state_nx == WAIT_DN);
    run_done_nx = (state == WAIT_DN) && nwc_done;
    frame_nx    = err_frame | (beat & (s_last != at_last));
    range_nx    = err_range | (beat & over_c);
    addr0_nx    = '0;
    din0_nx     = '0;
    wen0_nx     = '0;
    addr1_nx    = '0;
    din1_nx     = '0;
    wen1_nx     = '0;
    if (beat && state == LOAD_A) begin
      addr0_nx = count;
      din0_nx  = data_w;
      wen0_nx  = 8'hFF;
    end
    if (beat && state == LOAD_B) begin
      addr1_nx = count;
      din1_nx  = data_w;
      wen1_nx  = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ready   <= 1'b0;
      nwc_start <= 1'b0;
      busy      <= 1'b0;
      run_done  <= 1'b0;
      err_frame <= 1'b0;
      err_range <= 1'b0;
      addr0     <= '0;
      din0      <= '0;
      wen0      <= '0;
      addr1     <= '0;
      din1      <= '0;
      wen1      <= '0;
    end else begin
      s_ready   <= ready_nx;
      nwc_start <= start_nx;
      busy      <= busy_nx;
      run_done  <= run_done_nx;
      err_frame <= frame_nx;
      err_range <= range_nx;
      addr0     <= addr0_nx;
      din0      <= din0_nx;
      wen0      <= wen0_nx;
      addr1     <= addr1_nx;
      din1      <= din1_nx;
      wen1      <= wen1_nx;
    end
  end

endmodule

// File: tb/tb_nwc_input_loader.sv
// Scoreboard bench for nwc_input_loader: RAM writes, start/run handshake, framing, reset, range check.
module tb_nwc_input_loader;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 64;
  localparam int N = 2048;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] din0, din1;
  logic [7:0]        wen0, wen1;
  logic              nwc_start, nwc_done, busy, run_done, err_frame, err_range;

  int total = 0;
  int bad   = 0;
  int n0 = 0, n1 = 0;
  logic [75:0] exp_q[$];

  nwc_input_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .addr0(addr0), .din0(din0), .wen0(wen0), .addr1(addr1),
    .din1(din1), .wen1(wen1), .nwc_start(nwc_start), .nwc_done(nwc_done), .busy(busy),
    .run_done(run_done), .err_frame(err_frame), .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [63:0] d);
`ifdef NWC_LOADER_RANGE_CHECK_EN
    return {4'h0, d[59:0]};
`else
    return d;
`endif
  endfunction

  // Every RAM write must match the next scoreboard entry
  always @(negedge clk) begin
    if (wen0 != 8'h00 || wen1 != 8'h00) begin
      chk("wen_overlap", 128'(wen0 != 8'h00 && wen1 != 8'h00), 128'(0));
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 128'(1), 128'(0));
      end else if (wen0 != 8'h00) begin
        n0++;
        chk("ram0_write", {52'h0, 1'b0, addr0, din0, wen0}, {52'h0, exp_q.pop_front(), 8'hFF});
      end else begin
        n1++;
        chk("ram1_write", {52'h0, 1'b1, addr1, din1, wen1}, {52'h0, exp_q.pop_front(), 8'hFF});
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic l, input bit gaps, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      s_data  = d;
      s_last  = l;
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_valid && s_ready) ok = 1'b1;
    end
    if (!ok) chk("hs_timeout", 128'(0), 128'(1));
  endtask

  // kind 0: A[i]=i (A[3] out of range), B[i]=4096+i; 1: random; 2: counting with misplaced s_last in A
  task automatic load(input bit gaps, input int kind, input int n);
    logic [63:0] d;
    logic        l;
    bit          ok;
    for (int k = 0; k < n; k++) begin
      if (kind == 1) d = {4'h0, 28'($urandom()), 32'($urandom())};
      else if (kind == 0 && k == 3) d = 64'hF000_0000_0000_0005;
      else d = 64'(k + ((k >= N) ? N : 0));
      l = ((k % N) == N - 1);
      if (kind == 2 && k < N) l = (k == 100);
      send(d, l, gaps, ok);
      if (!ok) return;
      exp_q.push_back({(k >= N), 11'(k % N), exp_data(d)});
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, 128'({s_ready, nwc_start, busy, run_done, err_frame, err_range, wen0, wen1}), 128'(0));
    chk({tag, "_ram0"}, 128'({addr0, din0}), 128'(0));
    chk({tag, "_ram1"}, 128'({addr1, din1}), 128'(0));
  endtask

  // Final beat was accepted at the previous negedge: check the tail, then model the processor top
  task automatic finish_run(input bit stale, input int s0, input int s1);
    int  starts;
    bit  busy_ok;
    bit  seen;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("ready_drop", 128'(s_ready), 128'(0));
    chk("start_early", 128'(nwc_start), 128'(0));
    @(negedge clk);
    chk("start_latency", 128'(nwc_start), 128'(1));
    chk("busy_at_start", 128'(busy), 128'(1));
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    chk("ram0_count", 128'(n0 - s0), 128'(N));
    chk("ram1_count", 128'(n1 - s1), 128'(N));
    starts  = 1;
    busy_ok = 1'b1;
    for (int c = 0; c < (stale ? 2110 : 60); c++) begin
      @(negedge clk);
      if (stale && c == 9) nwc_done = 1'b0;
      if (nwc_start) starts++;
      if (!busy || run_done || s_ready) busy_ok = 1'b0;
    end
    chk("busy_span", 128'(busy_ok), 128'(1));
    chk("start_pulses", 128'(starts), 128'(1));
    nwc_done = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = run_done;
    end
    chk("run_done_seen", 128'(seen), 128'(1));
    chk("busy_clear", 128'(busy), 128'(0));
    chk("ready_after_run", 128'(s_ready), 128'(1));
    @(negedge clk);
    chk("run_done_pulse", 128'(run_done), 128'(0));
  endtask

  initial begin
    int s0, s1;
    bit ok;
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; nwc_done = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Counting load, no gaps, first run with done already low
    s0 = n0; s1 = n1;
    load(1'b0, 0, 2 * N);
    finish_run(1'b0, s0, s1);
    chk("frame_clean", 128'(err_frame), 128'(0));
`ifdef NWC_LOADER_RANGE_CHECK_EN
    chk("range_flag", 128'(err_range), 128'(1));
`else
    chk("range_flag", 128'(err_range), 128'(0));
`endif

    // Random data with valid gaps, stale done from the previous run
    s0 = n0; s1 = n1;
    load(1'b1, 1, 2 * N);
    finish_run(1'b1, s0, s1);

    // Misplaced and missing s_last in A
    s0 = n0; s1 = n1;
    load(1'b0, 2, 2 * N);
    chk("frame_err", 128'(err_frame), 128'(1));
    finish_run(1'b1, s0, s1);
    chk("frame_sticky", 128'(err_frame), 128'(1));

    // Reset in the middle of B
    load(1'b1, 1, N + 500);
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 64'h1234;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    chk("mid_reset_queue", 128'(exp_q.size()), 128'(0));
    rst_n   = 1'b1;
    s_valid = 1'b0;
    s0 = n0; s1 = n1;
    load(1'b0, 1, 2 * N);
    finish_run(1'b1, s0, s1);
    chk("frame_after_reset", 128'(err_frame), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
